// File: rtl/axi_mem_bridge_pkg.sv
// Shared types and constants for the AXI4-to-TSIM memory bridge.
package axi_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } state_t;

  localparam logic       MEM_OP_RD       = 1'b0;
  localparam logic       MEM_OP_WR       = 1'b1;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int unsigned STAT_BITS      = 32;

endpackage

// File: rtl/axi_mem_bridge.sv
// AXI4 m_axi (one burst, no IDs) to TSIM mem_req/wr/rd; R and W beats pass through with zero added latency.
// RREADY backpressures via mem_rd_ready, W beats always accepted; AXI_MEM_BRIDGE_STATS_EN adds beat counters.
module axi_mem_bridge
  import axi_mem_bridge_pkg::*;
#(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 32,
  parameter int unsigned MEM_DATA_BITS = 64
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     s_axi_ARVALID,
  output logic                     s_axi_ARREADY,
  input  logic [MEM_ADDR_BITS-1:0] s_axi_ARADDR,
  input  logic [MEM_LEN_BITS-1:0]  s_axi_ARLEN,
  output logic                     s_axi_RVALID,
  input  logic                     s_axi_RREADY,
  output logic [MEM_DATA_BITS-1:0] s_axi_RDATA,
  output logic                     s_axi_RLAST,
  output logic [1:0]               s_axi_RRESP,
  input  logic                     s_axi_AWVALID,
  output logic                     s_axi_AWREADY,
  input  logic [MEM_ADDR_BITS-1:0] s_axi_AWADDR,
  input  logic [MEM_LEN_BITS-1:0]  s_axi_AWLEN,
  input  logic                     s_axi_WVALID,
  output logic                     s_axi_WREADY,
  input  logic [MEM_DATA_BITS-1:0] s_axi_WDATA,
  input  logic                     s_axi_WLAST,
  output logic                     s_axi_BVALID,
  input  logic                     s_axi_BREADY,
  output logic [1:0]               s_axi_BRESP,
`ifdef AXI_MEM_BRIDGE_STATS_EN
  output logic [STAT_BITS-1:0]     stat_rd_beats,
  output logic [STAT_BITS-1:0]     stat_wr_beats,
`endif
  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready
);

  localparam logic [MEM_LEN_BITS-1:0] LEN_ONE = 1;

  state_t                   r_state;
  state_t                   w_nxt_state;
  logic [MEM_LEN_BITS-1:0]  r_cnt;
  logic [MEM_LEN_BITS-1:0]  r_len;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic                     r_prio;
  logic                     r_err;

  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_rd_beat;
  logic w_wr_beat;
  logic w_cnt_zero;

  // r_prio low: read wins a tie; flips to the other channel after every grant.
  assign w_gnt_rd   = s_axi_ARVALID & (~s_axi_AWVALID | ~r_prio);
  assign w_gnt_wr   = s_axi_AWVALID & (~s_axi_ARVALID |  r_prio);
  assign w_rd_beat  = (r_state == ST_RD_DATA) & mem_rd_valid & s_axi_RREADY;
  assign w_wr_beat  = (r_state == ST_WR_DATA) & s_axi_WVALID;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_rd) begin
          w_nxt_state = ST_RD_REQ;
        end else if (w_gnt_wr) begin
          w_nxt_state = ST_WR_REQ;
        end
      end
      ST_RD_REQ:  w_nxt_state = ST_RD_DATA;
      ST_RD_DATA: if (w_rd_beat && w_cnt_zero) w_nxt_state = ST_IDLE;
      ST_WR_REQ:  w_nxt_state = ST_WR_DATA;
      // AWLEN, not WLAST, decides where the burst ends.
      ST_WR_DATA: if (w_wr_beat && w_cnt_zero) w_nxt_state = ST_WR_RESP;
      ST_WR_RESP: if (s_axi_BREADY) w_nxt_state = ST_IDLE;
      default:    w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi_ARREADY  = 1'b0;
    s_axi_AWREADY  = 1'b0;
    s_axi_RVALID   = 1'b0;
    s_axi_RDATA    = '0;
    s_axi_RLAST    = 1'b0;
    s_axi_RRESP    = AXI_RESP_OKAY;
    s_axi_WREADY   = 1'b0;
    s_axi_BVALID   = 1'b0;
    s_axi_BRESP    = AXI_RESP_OKAY;
    mem_req_valid  = 1'b0;
    mem_req_opcode = MEM_OP_RD;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_axi_ARREADY = w_gnt_rd;
        s_axi_AWREADY = w_gnt_wr;
      end
      ST_RD_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = MEM_OP_RD;
      end
      ST_RD_DATA: begin
        s_axi_RVALID = mem_rd_valid;
        s_axi_RDATA  = mem_rd_bits;
        s_axi_RLAST  = w_cnt_zero;
        mem_rd_ready = s_axi_RREADY;
      end
      ST_WR_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = MEM_OP_WR;
      end
      ST_WR_DATA: begin
        s_axi_WREADY = 1'b1;
        mem_wr_valid = s_axi_WVALID;
        mem_wr_bits  = s_axi_WDATA;
      end
      ST_WR_RESP: begin
        s_axi_BVALID = 1'b1;
        s_axi_BRESP  = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      default: ;
    endcase
  end

  assign mem_req_len  = r_len;
  assign mem_req_addr = r_addr;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt  <= '0;
      r_len  <= '0;
      r_addr <= '0;
      r_prio <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_gnt_rd) begin
        r_addr <= s_axi_ARADDR;
        r_len  <= s_axi_ARLEN;
        r_cnt  <= s_axi_ARLEN;
        r_prio <= 1'b1;
      end else if (r_state == ST_IDLE && w_gnt_wr) begin
        r_addr <= s_axi_AWADDR;
        r_len  <= s_axi_AWLEN;
        r_cnt  <= s_axi_AWLEN;
        r_prio <= 1'b0;
      end else if ((w_rd_beat || w_wr_beat) && !w_cnt_zero) begin
        r_cnt <= r_cnt - LEN_ONE;
      end

      if (r_state == ST_WR_REQ) begin
        r_err <= 1'b0;
      end else if (w_wr_beat && (s_axi_WLAST != w_cnt_zero)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef AXI_MEM_BRIDGE_STATS_EN
  logic [STAT_BITS-1:0] r_stat_rd;
  logic [STAT_BITS-1:0] r_stat_wr;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else begin
      if (w_rd_beat) r_stat_rd <= r_stat_rd + 32'd1;
      if (w_wr_beat) r_stat_wr <= r_stat_wr + 32'd1;
    end
  end

  assign stat_rd_beats = r_stat_rd;
  assign stat_wr_beats = r_stat_wr;
`endif

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Self-checking bench for axi_mem_bridge: vector table of bursts plus arbitration and mid-burst reset sequences.
module tb_axi_mem_bridge;

  localparam int TMO = 40;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        s_axi_ARVALID, s_axi_ARREADY;
  logic [31:0] s_axi_ARADDR;
  logic [7:0]  s_axi_ARLEN;
  logic        s_axi_RVALID, s_axi_RREADY;
  logic [63:0] s_axi_RDATA;
  logic        s_axi_RLAST;
  logic [1:0]  s_axi_RRESP;
  logic        s_axi_AWVALID, s_axi_AWREADY;
  logic [31:0] s_axi_AWADDR;
  logic [7:0]  s_axi_AWLEN;
  logic        s_axi_WVALID, s_axi_WREADY;
  logic [63:0] s_axi_WDATA;
  logic        s_axi_WLAST;
  logic        s_axi_BVALID, s_axi_BREADY;
  logic [1:0]  s_axi_BRESP;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid, mem_rd_ready;
  logic [63:0] mem_rd_bits;
`ifdef AXI_MEM_BRIDGE_STATS_EN
  logic [31:0] stat_rd_beats, stat_wr_beats;
  int          n_rd_seen = 0;
  int          n_wr_seen = 0;
`endif

  always #5 ap_clk = ~ap_clk;

  axi_mem_bridge dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
    .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARLEN(s_axi_ARLEN),
    .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY),
    .s_axi_RDATA(s_axi_RDATA), .s_axi_RLAST(s_axi_RLAST), .s_axi_RRESP(s_axi_RRESP),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
    .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWLEN(s_axi_AWLEN),
    .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
    .s_axi_WDATA(s_axi_WDATA), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY), .s_axi_BRESP(s_axi_BRESP),
`ifdef AXI_MEM_BRIDGE_STATS_EN
    .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
`endif
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready)
  );

  logic [181:0] w_all;
  assign w_all = {s_axi_ARREADY, s_axi_RVALID, s_axi_RDATA, s_axi_RLAST, s_axi_RRESP,
                  s_axi_AWREADY, s_axi_WREADY, s_axi_BVALID, s_axi_BRESP,
                  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
                  mem_wr_valid, mem_wr_bits, mem_rd_ready};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not seen / not expected", name);
  endtask

  typedef struct packed { logic op; logic [7:0] len; logic [31:0] addr; } req_t;
  typedef struct packed { logic [63:0] d; logic last; } rbeat_t;

  req_t        exp_req_q[$];
  logic [63:0] exp_wr_q[$];
  rbeat_t      exp_r_q[$];
  logic [1:0]  exp_b_q[$];
  logic        exp_gnt_q[$];

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
    return {a, (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000};
  endfunction

  // Scoreboard: pop expected items as the DUT presents each transfer.
  req_t        m_req;
  rbeat_t      m_r;
  logic [63:0] m_w;
  logic [1:0]  m_b;
  logic        m_g;
  always @(negedge ap_clk) begin
    #2;
    if (ap_rst_n) begin
      if (s_axi_ARVALID && s_axi_ARREADY) begin
        if (exp_gnt_q.size() == 0) note_fail("grant_ar_unexpected");
        else begin m_g = exp_gnt_q.pop_front(); check("grant_order_ar", 1'b0, m_g); end
      end
      if (s_axi_AWVALID && s_axi_AWREADY) begin
        if (exp_gnt_q.size() == 0) note_fail("grant_aw_unexpected");
        else begin m_g = exp_gnt_q.pop_front(); check("grant_order_aw", 1'b1, m_g); end
      end
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) note_fail("mem_req_unexpected");
        else begin
          m_req = exp_req_q.pop_front();
          check("mem_req", {mem_req_opcode, mem_req_len, mem_req_addr}, m_req);
        end
      end
      if (mem_wr_valid) begin
        if (exp_wr_q.size() == 0) note_fail("mem_wr_unexpected");
        else begin m_w = exp_wr_q.pop_front(); check("mem_wr_bits", mem_wr_bits, m_w); end
`ifdef AXI_MEM_BRIDGE_STATS_EN
        n_wr_seen++;
`endif
      end
      if (s_axi_RVALID && s_axi_RREADY) begin
        if (exp_r_q.size() == 0) note_fail("r_beat_unexpected");
        else begin
          m_r = exp_r_q.pop_front();
          check("r_beat", {s_axi_RDATA, s_axi_RLAST}, m_r);
          check("rresp", s_axi_RRESP, 2'b00);
        end
`ifdef AXI_MEM_BRIDGE_STATS_EN
        n_rd_seen++;
`endif
      end
      if (s_axi_BVALID && s_axi_BREADY) begin
        if (exp_b_q.size() == 0) note_fail("b_unexpected");
        else begin m_b = exp_b_q.pop_front(); check("bresp", s_axi_BRESP, m_b); end
      end
    end else begin
`ifdef AXI_MEM_BRIDGE_STATS_EN
      n_rd_seen = 0;
      n_wr_seen = 0;
`endif
    end
  end

  task automatic ar_hs(input logic [31:0] a, input logic [7:0] l);
    bit ok;
    exp_req_q.push_back(req_t'({1'b0, l, a}));
    exp_gnt_q.push_back(1'b0);
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = a; s_axi_ARLEN = l;
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      #1;
      if (s_axi_ARREADY) begin ok = 1'b1; break; end
      @(negedge ap_clk);
    end
    if (!ok) note_fail("ar_handshake_timeout");
    @(negedge ap_clk);
    s_axi_ARVALID = 1'b0;
  endtask

  task automatic aw_hs(input logic [31:0] a, input logic [7:0] l);
    bit ok;
    exp_req_q.push_back(req_t'({1'b1, l, a}));
    exp_gnt_q.push_back(1'b1);
    s_axi_AWVALID = 1'b1; s_axi_AWADDR = a; s_axi_AWLEN = l;
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      #1;
      if (s_axi_AWREADY) begin ok = 1'b1; break; end
      @(negedge ap_clk);
    end
    if (!ok) note_fail("aw_handshake_timeout");
    @(negedge ap_clk);
    s_axi_AWVALID = 1'b0;
  endtask

  task automatic serve_read(input logic [31:0] a, input logic [7:0] l, input bit toggle);
    bit ok;
    logic [63:0] d;
    @(negedge ap_clk);
    for (int i = 0; i <= int'(l); i++) begin
      d = beat_data(a, i);
      mem_rd_valid = 1'b1; mem_rd_bits = d;
      exp_r_q.push_back(rbeat_t'({d, (i == int'(l))}));
      ok = 1'b0;
      for (int t = 0; t < TMO; t++) begin
        s_axi_RREADY = toggle ? ~s_axi_RREADY : 1'b1;
        #1;
        check("mem_rd_ready_follows", mem_rd_ready, s_axi_RREADY);
        check("rvalid_follows", s_axi_RVALID, 1'b1);
        ok = mem_rd_ready;
        @(negedge ap_clk);
        if (ok) break;
      end
      if (!ok) begin note_fail("read_beat_timeout"); break; end
    end
    mem_rd_valid = 1'b0; mem_rd_bits = '0; s_axi_RREADY = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] a, input int wlast_idx, input int nbeats);
    bit ok;
    @(negedge ap_clk);
    for (int i = 0; i < nbeats; i++) begin
      s_axi_WVALID = 1'b1; s_axi_WDATA = beat_data(a, i); s_axi_WLAST = (i == wlast_idx);
      exp_wr_q.push_back(beat_data(a, i));
      ok = 1'b0;
      for (int t = 0; t < TMO; t++) begin
        #1;
        ok = s_axi_WREADY;
        @(negedge ap_clk);
        if (ok) break;
      end
      if (!ok) begin note_fail("write_beat_timeout"); break; end
    end
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
  endtask

  task automatic take_b(input logic [1:0] exp_resp);
    bit ok;
    exp_b_q.push_back(exp_resp);
    s_axi_BREADY = 1'b0;
    #1 check("bvalid_hold_1", s_axi_BVALID, 1'b1);
    @(negedge ap_clk);
    #1 check("bvalid_hold_2", s_axi_BVALID, 1'b1);
    @(negedge ap_clk);
    s_axi_BREADY = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      #1;
      if (s_axi_BVALID) begin ok = 1'b1; break; end
      @(negedge ap_clk);
    end
    if (!ok) note_fail("b_timeout");
    @(negedge ap_clk);
    s_axi_BREADY = 1'b0;
    #1 check("bvalid_low_after", s_axi_BVALID, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          wlast_idx;
    bit          rr_toggle;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi_ARVALID = 0; s_axi_ARADDR = 0; s_axi_ARLEN = 0; s_axi_RREADY = 0;
    s_axi_AWVALID = 0; s_axi_AWADDR = 0; s_axi_AWLEN = 0;
    s_axi_WVALID = 0; s_axi_WDATA = 0; s_axi_WLAST = 0; s_axi_BREADY = 0;
    mem_rd_valid = 0; mem_rd_bits = 0;

    vecs[0]  = '{1'b0, 32'h0000_1000, 8'd3,   3,   1'b0, 2'b00};
    vecs[1]  = '{1'b1, 32'h0000_2000, 8'd1,   1,   1'b0, 2'b00};
    vecs[2]  = '{1'b1, 32'h0000_3000, 8'd2,   1,   1'b0, 2'b10};
    vecs[3]  = '{1'b0, 32'h0000_4000, 8'd7,   7,   1'b1, 2'b00};
    vecs[4]  = '{1'b0, 32'h0000_5004, 8'd0,   0,   1'b0, 2'b00};
    vecs[5]  = '{1'b1, 32'h0000_6000, 8'd0,   0,   1'b0, 2'b00};
    vecs[6]  = '{1'b1, 32'h0000_7000, 8'd0,   -1,  1'b0, 2'b10};
    vecs[7]  = '{1'b0, 32'h0000_0FF8, 8'd255, 255, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 32'h0000_8000, 8'd255, 255, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 32'h0000_9000, 8'd3,   5,   1'b0, 2'b10};
    vecs[10] = '{1'b1, 32'h0000_9800, 8'd1,   1,   1'b0, 2'b00};

    #3 check("reset_outputs", w_all, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1 check("idle_outputs", w_all, 0);
    @(negedge ap_clk);

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].wr) begin
        aw_hs(vecs[k].addr, vecs[k].len);
        send_w(vecs[k].addr, vecs[k].wlast_idx, int'(vecs[k].len) + 1);
        take_b(vecs[k].exp_resp);
      end else begin
        ar_hs(vecs[k].addr, vecs[k].len);
        serve_read(vecs[k].addr, vecs[k].len, vecs[k].rr_toggle);
      end
    end

    // Two back-to-back AR/AW collisions: read wins first, write wins the second.
    @(negedge ap_clk);
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = 32'hC000; s_axi_ARLEN = 8'd0;
    s_axi_AWVALID = 1'b1; s_axi_AWADDR = 32'hD000; s_axi_AWLEN = 8'd0;
    #1 check("arb1_arready", s_axi_ARREADY, 1'b1);
    check("arb1_awready", s_axi_AWREADY, 1'b0);
    ar_hs(32'hC000, 8'd0);
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = 32'hE000; s_axi_ARLEN = 8'd0;
    #1 check("busy_arready", s_axi_ARREADY, 1'b0);
    check("busy_awready", s_axi_AWREADY, 1'b0);
    serve_read(32'hC000, 8'd0, 1'b0);
    #1 check("arb2_awready", s_axi_AWREADY, 1'b1);
    check("arb2_arready", s_axi_ARREADY, 1'b0);
    aw_hs(32'hD000, 8'd0);
    send_w(32'hD000, 0, 1);
    take_b(2'b00);
    ar_hs(32'hE000, 8'd0);
    serve_read(32'hE000, 8'd0, 1'b0);

    // Asynchronous reset in the middle of a 16-beat write.
    @(negedge ap_clk);
    aw_hs(32'hA000, 8'd15);
    send_w(32'hA000, 15, 5);
    s_axi_WDATA = 64'hDEAD_BEEF_0000_1111;
    mem_rd_valid = 1'b1; mem_rd_bits = 64'h1234_5678_9ABC_DEF0;
    s_axi_RREADY = 1'b1; s_axi_BREADY = 1'b1;
    #1 check("pre_rst_wready", s_axi_WREADY, 1'b1);
    #2 ap_rst_n = 1'b0;
    #1 check("rst_mid_outputs", w_all, 0);
    exp_req_q.delete(); exp_wr_q.delete(); exp_r_q.delete(); exp_b_q.delete(); exp_gnt_q.delete();
    @(negedge ap_clk);
    s_axi_WDATA = 0; mem_rd_valid = 0; mem_rd_bits = 0; s_axi_RREADY = 0; s_axi_BREADY = 0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1 check("post_rst_outputs", w_all, 0);
    @(negedge ap_clk);
    ar_hs(32'hB000, 8'd0);
    serve_read(32'hB000, 8'd0, 1'b0);

    repeat (3) @(negedge ap_clk);
    check("req_q_drained", exp_req_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("r_q_drained", exp_r_q.size(), 0);
    check("b_q_drained", exp_b_q.size(), 0);
    check("gnt_q_drained", exp_gnt_q.size(), 0);
`ifdef AXI_MEM_BRIDGE_STATS_EN
    check("stat_rd_beats", stat_rd_beats, n_rd_seen);
    check("stat_wr_beats", stat_wr_beats, n_wr_seen);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
